// File: rtl/bcd_down_timer_if.sv
// bcd_down_timer_if
//   Control and status bundle for the BCD down-timer.
//   master: drives ce/load/ld_val/start/stop/reload_en and observes Q/TC/CEO/busy/done.
//   slave : the timer itself.
//   Q holds N_DIG BCD digits, digit 0 in Q[3:0].
interface bcd_down_timer_if #(
    parameter int N_DIG = 4
);
    logic                 ce;
    logic                 load;
    logic [4*N_DIG-1:0]   ld_val;
    logic                 start;
    logic                 stop;
    logic                 reload_en;
    logic [4*N_DIG-1:0]   Q;
    logic                 TC;
    logic                 CEO;
    logic                 busy;
    logic                 done;

    modport master (
        output ce, load, ld_val, start, stop, reload_en,
        input  Q, TC, CEO, busy, done
    );

    modport slave (
        input  ce, load, ld_val, start, stop, reload_en,
        output Q, TC, CEO, busy, done
    );
endinterface

// File: rtl/bcd_down_timer.sv
// bcd_down_timer
//   Multi-digit BCD down-counter. Loads a decimal value, counts it down to zero on
//   ce pulses while running, flags terminal count and optionally auto-reloads so it
//   can serve as a programmable decimal divider.
// Ports
//   clk : rising-edge clock
//   rn  : asynchronous active-low reset
//   bus : bcd_down_timer_if.slave
//         in : ce, load, ld_val, start, stop, reload_en
//         out: Q (registered count), TC (Q==0), CEO (expiry pulse), busy (RUN), done (DONE)
module bcd_down_timer #(
    parameter int N_DIG = 4
) (
    input  logic              clk,
    input  logic              rn,
    bcd_down_timer_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state, w_state_nxt;
    logic [4*N_DIG-1:0] r_q, r_rld;
    logic [4*N_DIG-1:0] w_q_nxt, w_rld_nxt;
    logic [4*N_DIG-1:0] w_clamp, w_dec;
    logic               w_tc, w_brw;
    logic [3:0]         w_dig;

    assign w_tc = (r_q == '0);

    // Clamp each loaded digit into 0..9 so Q can never hold a non-BCD digit.
    // Decrement: a digit borrows only when every lower digit is zero; a borrowing
    // zero wraps to 9.
    always_comb begin
        w_clamp = '0;
        w_dec   = r_q;
        w_brw   = 1'b1;
        w_dig   = '0;
        for (int k = 0; k < N_DIG; k++) begin
            w_dig = bus.ld_val[4*k +: 4];
            w_clamp[4*k +: 4] = (w_dig > 4'd9) ? 4'd9 : w_dig;
            w_dig = r_q[4*k +: 4];
            if (w_brw)
                w_dec[4*k +: 4] = (w_dig == 4'd0) ? 4'd9 : w_dig - 4'd1;
            w_brw = w_brw & (w_dig == 4'd0);
        end
    end

    // Next state, priority load > stop > start > ce.
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_rld_nxt   = r_rld;
        if (bus.load) begin
            w_q_nxt     = w_clamp;
            w_rld_nxt   = w_clamp;
            w_state_nxt = S_IDLE;
        end else if (bus.stop && r_state == S_RUN) begin
            w_state_nxt = S_IDLE;
        end else if (bus.start && r_state == S_IDLE) begin
            if (!w_tc)
                w_state_nxt = S_RUN;
        end else if (bus.start && r_state == S_DONE) begin
            w_q_nxt     = r_rld;
            w_state_nxt = (r_rld != '0) ? S_RUN : S_DONE;
        end else if (bus.ce && r_state == S_RUN) begin
            if (!w_tc) begin
                w_q_nxt = w_dec;
            end else if (bus.reload_en && r_rld != '0) begin
                // Expiry with reload: period is V+1 ce pulses.
                w_q_nxt = r_rld;
            end else begin
                w_state_nxt = S_DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rn) begin
        if (!rn) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_rld   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_rld   <= w_rld_nxt;
        end
    end

    assign bus.Q    = r_q;
    assign bus.TC   = w_tc;
    assign bus.CEO  = bus.ce & (r_state == S_RUN) & w_tc;
    assign bus.busy = (r_state == S_RUN);
    assign bus.done = (r_state == S_DONE);
endmodule

// File: tb/tb_bcd_down_timer.sv
// tb_bcd_down_timer
//   Directed vectors for bcd_down_timer. Each stimulus cycle pushes the values the
//   outputs must show during that cycle (registers after the previous edge, combinational
//   outputs for the current inputs); a monitor pops and compares on the falling edge.
module tb_bcd_down_timer;
    logic clk = 1'b0;
    logic rn  = 1'b0;
    always #5 clk = ~clk;

    bcd_down_timer_if #(.N_DIG(4)) bus();
    bcd_down_timer #(.N_DIG(4)) dut (.clk(clk), .rn(rn), .bus(bus));

    typedef struct {
        int          cyc;
        string       nm;
        logic [15:0] q;
        logic        ceo;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            total++;
            if (e.cyc != cyc || bus.Q !== e.q || bus.TC !== (e.q == 16'h0) ||
                bus.CEO !== e.ceo || bus.busy !== e.busy || bus.done !== e.done) begin
                bad++;
                $display("FAIL %s: got Q=%h TC=%b CEO=%b busy=%b done=%b, want Q=%h TC=%b CEO=%b busy=%b done=%b",
                         e.nm, bus.Q, bus.TC, bus.CEO, bus.busy, bus.done,
                         e.q, (e.q == 16'h0), e.ceo, e.busy, e.done);
            end
        end
    end

    task automatic drv(input logic c, input logic ld, input logic [15:0] v,
                       input logic st, input logic sp, input logic rl);
        @(posedge clk);
        #1;
        bus.ce = c; bus.load = ld; bus.ld_val = v;
        bus.start = st; bus.stop = sp; bus.reload_en = rl;
    endtask

    task automatic chk(input string nm, input logic [15:0] q, input logic ceo,
                       input logic b, input logic d);
        exp_t x;
        x.cyc = cyc; x.nm = nm; x.q = q; x.ceo = ceo; x.busy = b; x.done = d;
        sb.push_back(x);
    endtask

    initial begin
        bus.ce = 0; bus.load = 0; bus.ld_val = '0;
        bus.start = 0; bus.stop = 0; bus.reload_en = 0;

        // reset
        drv(1, 0, 16'h0, 1, 0, 0);       chk("reset", 16'h0, 0, 0, 0);
        drv(0, 0, 16'h0, 0, 0, 0);
        rn = 1'b1;

        // 1: one-shot count 3 -> 0
        drv(0, 1, 16'h0003, 0, 0, 0);    chk("t1_ld", 16'h0, 0, 0, 0);
        drv(0, 0, 16'h0, 1, 0, 0);       chk("t1_st", 16'h3, 0, 0, 0);
        drv(1, 0, 16'h0, 0, 0, 0);       chk("t1_ce1", 16'h3, 0, 1, 0);
        drv(1, 0, 16'h0, 0, 0, 0);       chk("t1_ce2", 16'h2, 0, 1, 0);
        drv(1, 0, 16'h0, 0, 0, 0);       chk("t1_ce3", 16'h1, 0, 1, 0);
        drv(1, 0, 16'h0, 0, 0, 0);       chk("t1_ce4", 16'h0, 1, 1, 0);
        drv(0, 0, 16'h0, 0, 0, 0);       chk("t1_done", 16'h0, 0, 0, 1);

        // 2: multi-digit borrow
        drv(0, 1, 16'h1000, 0, 0, 0);    chk("t2_ld", 16'h0, 0, 0, 1);
        drv(0, 0, 16'h0, 1, 0, 0);       chk("t2_st", 16'h1000, 0, 0, 0);
        drv(1, 0, 16'h0, 0, 0, 0);       chk("t2_ce", 16'h1000, 0, 1, 0);
        drv(0, 0, 16'h0, 0, 1, 0);       chk("t2_borrow", 16'h0999, 0, 1, 0);

        // 3: auto-reload, period 3
        drv(0, 1, 16'h0002, 0, 0, 1);    chk("t3_ld", 16'h0999, 0, 0, 0);
        drv(0, 0, 16'h0, 1, 0, 1);       chk("t3_st", 16'h2, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            drv(1, 0, 16'h0, 0, 0, 1);
            chk($sformatf("t3_ce%0d", i + 1), 16'(2 - (i % 3)), (i % 3) == 2, 1, 0);
        end
        drv(0, 0, 16'h0, 0, 1, 0);       chk("t3_stop", 16'h2, 0, 1, 0);

        // 4: clamp, stop with ce, resume
        drv(0, 1, 16'h00A5, 0, 0, 0);    chk("t4_ld", 16'h2, 0, 0, 0);
        drv(0, 0, 16'h0, 1, 0, 0);       chk("t4_clamp", 16'h0095, 0, 0, 0);
        drv(1, 0, 16'h0, 0, 1, 0);       chk("t4_stopce", 16'h0095, 0, 1, 0);
        drv(1, 0, 16'h0, 0, 0, 0);       chk("t4_held", 16'h0095, 0, 0, 0);
        drv(1, 0, 16'h0, 1, 0, 0);       chk("t4_resume", 16'h0095, 0, 0, 0);
        drv(1, 0, 16'h0, 0, 0, 0);       chk("t4_run", 16'h0095, 0, 1, 0);
        drv(0, 1, 16'hFA5C, 0, 0, 0);    chk("t4_dec94", 16'h0094, 0, 1, 0);
        drv(0, 1, 16'h0001, 0, 0, 0);    chk("t4_clamp4", 16'h9959, 0, 0, 0);
        drv(0, 0, 16'h0, 1, 0, 0);       chk("t4_ld1", 16'h1, 0, 0, 0);
        drv(1, 0, 16'h0, 0, 0, 0);       chk("t4_ce1", 16'h1, 0, 1, 0);
        drv(1, 0, 16'h0, 0, 0, 0);       chk("t4_exp", 16'h0, 1, 1, 0);
        drv(0, 0, 16'h0, 1, 0, 0);       chk("t4_done", 16'h0, 0, 0, 1);
        // start from DONE reloads the stored value
        drv(1, 0, 16'h0, 0, 0, 0);       chk("t4_rerun", 16'h1, 0, 1, 0);
        drv(1, 0, 16'h0, 0, 0, 0);       chk("t4_exp2", 16'h0, 1, 1, 0);
        drv(0, 0, 16'h0, 0, 0, 0);       chk("t4_done2", 16'h0, 0, 0, 1);

        // 5: load beats start in DONE
        drv(0, 1, 16'h0007, 1, 0, 0);    chk("t5_ldst", 16'h0, 0, 0, 1);
        drv(0, 0, 16'h0, 0, 0, 0);       chk("t5_idle", 16'h7, 0, 0, 0);
        drv(1, 0, 16'h0, 0, 0, 0);       chk("t5_noce", 16'h7, 0, 0, 0);

        // 6: async reset mid-RUN
        drv(0, 1, 16'h0042, 0, 0, 0);    chk("t6_ld", 16'h7, 0, 0, 0);
        drv(0, 0, 16'h0, 1, 0, 0);       chk("t6_st", 16'h42, 0, 0, 0);
        drv(0, 0, 16'h0, 0, 0, 0);       chk("t6_run", 16'h42, 0, 1, 0);
        drv(1, 0, 16'h0, 0, 0, 0);
        rn = 1'b0;                       chk("t6_rst", 16'h0, 0, 0, 0);
        drv(1, 0, 16'h0, 1, 0, 0);
        rn = 1'b1;                       chk("t6_st0", 16'h0, 0, 0, 0);
        drv(1, 0, 16'h0, 0, 0, 0);       chk("t6_ign", 16'h0, 0, 0, 0);
        drv(0, 0, 16'h0, 0, 0, 0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending checks, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
